// File: rtl/vga_rx_monitor_if.sv
// Pin-level and result bundle for the VGA RGB444 receive monitor.
// The master drives the VGA pins and observes the results. The slave is the
// monitor, which samples the pins and reports timing, pixels and CRC.
interface vga_rx_monitor_if;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] pixel;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic [10:0] h_total;
  logic [9:0]  v_total;
  logic [23:0] r_sum;
  logic [23:0] g_sum;
  logic [23:0] b_sum;

  modport master (
    output red, green, blue, hsync, vsync,
    input  pixel_valid, x, y, pixel, locked, frame_done, frame_crc,
           h_total, v_total, r_sum, g_sum, b_sum
  );

  modport slave (
    input  red, green, blue, hsync, vsync,
    output pixel_valid, x, y, pixel, locked, frame_done, frame_crc,
           h_total, v_total, r_sum, g_sum, b_sum
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA RGB444 receive monitor: registers the pins, recovers line/frame
// timing, locks to a stable timing and reports active-pixel coordinates
// plus a CRC-16-CCITT over each locked frame.
// Optional macro VGA_RX_CHANNEL_SUM_EN adds per-channel pixel sums that are
// latched alongside frame_crc. Without it, r_sum/g_sum/b_sum read 0.
module vga_rx_monitor #(
  parameter int unsigned H_START         = 144,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_START         = 35,
  parameter int unsigned V_ACTIVE        = 480,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  vga_rx_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Level of a sync pin when it is not asserted.
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);

  // CRC-16-CCITT (0x1021), 12 data bits per call, MSB first.
  function automatic logic [15:0] crc16_12(input logic [15:0] crc_in,
                                           input logic [11:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Stage-1 pin registers and the previous sync levels for edge detection.
  logic [3:0] red_q, green_q, blue_q;
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;

  // Timing counters and measurements.
  logic [10:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] h_total_q, h_total_d;
  logic [9:0]  v_total_q, v_total_d;

  // Lock FSM state and its registered outputs.
  state_t      state_q;
  logic [10:0] h_ref_q;
  logic [9:0]  v_ref_q;
  logic        locked_q;
  logic        frame_done_q;
  logic [15:0] frame_crc_q;

  // Pixel output registers and the running CRC.
  logic        pixel_valid_q;
  logic [9:0]  x_q, y_q;
  logic [11:0] pixel_q;
  logic [15:0] crc_q, crc_d, crc_upd, crc_fin;

  logic [11:0] pixel_s1;
  logic        hs_edge, vs_edge;
  logic        in_win, pix_ok, lock_lost, frame_end;
  logic [9:0]  x_val, y_val;

  assign pixel_s1 = {red_q, green_q, blue_q};
  assign hs_edge  = (hs_q != SYNC_IDLE) && (hs_prev_q == SYNC_IDLE);
  assign vs_edge  = (vs_q != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);

  // Register the pins once; the previous sync level feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      hs_prev_q <= SYNC_IDLE;
      vs_prev_q <= SYNC_IDLE;
    end else begin
      red_q     <= bus.red;
      green_q   <= bus.green;
      blue_q    <= bus.blue;
      hs_q      <= bus.hsync;
      vs_q      <= bus.vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  // Next counter values; a coincident vsync edge overrides the line count.
  always_comb begin
    hcnt_inc  = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    hcnt_d    = hcnt_inc;
    vcnt_d    = vcnt_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    if (hs_edge) begin
      h_total_d = hcnt_inc;
      hcnt_d    = '0;
      vcnt_d    = (vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1;
    end
    if (vs_edge) begin
      v_total_d = vcnt_q;
      vcnt_d    = '0;
    end
  end

  // Commit counters and period measurements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
    end
  end

  assign in_win = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                  (vcnt_q >= V_LO) && (vcnt_q < V_HI);
  assign pix_ok = in_win && (state_q == ST_LOCKED);
  assign x_val  = 10'(hcnt_q - H_LO);
  assign y_val  = vcnt_q - V_LO;

  assign lock_lost = (hs_edge && (hcnt_inc != h_ref_q)) ||
                     (hcnt_q == 11'h7FF) ||
                     (vs_edge && (vcnt_q != v_ref_q));
  assign frame_end = (state_q == ST_LOCKED) && vs_edge && !lock_lost;

  // CRC including the pixel currently in stage 1, so a frame end that lands
  // on a valid pixel still captures it.
  always_comb begin
    crc_upd = crc16_12(crc_q, pixel_s1);
    crc_fin = pix_ok ? crc_upd : crc_q;
    crc_d   = vs_edge ? 16'hFFFF : crc_fin;
  end

  // Running CRC over valid pixels, restarted at every frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 16'hFFFF;
    else        crc_q <= crc_d;
  end

  // Second pipeline stage: window flag, coordinates and pixel value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_q       <= '0;
    end else begin
      pixel_valid_q <= pix_ok;
      x_q           <= in_win ? x_val : 10'd0;
      y_q           <= in_win ? y_val : 10'd0;
      pixel_q       <= pixel_s1;
    end
  end

  // Lock FSM: measure a frame, confirm it on the next, then track it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      h_ref_q      <= '0;
      v_ref_q      <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_crc_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (vs_edge) state_q <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vs_edge) begin
            h_ref_q <= h_total_d;
            v_ref_q <= vcnt_q;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (vs_edge) begin
            if ((h_total_d == h_ref_q) && (vcnt_q == v_ref_q)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              h_ref_q <= h_total_d;
              v_ref_q <= vcnt_q;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_lost) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end else if (frame_end) begin
            frame_done_q <= 1'b1;
            frame_crc_q  <= crc_fin;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_RX_CHANNEL_SUM_EN
  // One accumulator per channel; channel 0 is red, 1 green, 2 blue.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sum
    logic [3:0]  chan;
    logic [23:0] acc_q, sum_q, acc_fin;
    assign chan    = pixel_s1[11 - 4*gi -: 4];
    assign acc_fin = acc_q + (pix_ok ? 24'(chan) : 24'd0);

    // Accumulate valid pixels per frame and latch the total at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        sum_q <= '0;
      end else begin
        acc_q <= vs_edge ? 24'd0 : acc_fin;
        if (frame_end) sum_q <= acc_fin;
      end
    end
  end

  assign bus.r_sum = g_sum[0].sum_q;
  assign bus.g_sum = g_sum[1].sum_q;
  assign bus.b_sum = g_sum[2].sum_q;
`else
  assign bus.r_sum = '0;
  assign bus.g_sum = '0;
  assign bus.b_sum = '0;
`endif

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.pixel       = pixel_q;
  assign bus.locked      = locked_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_crc   = frame_crc_q;
  assign bus.h_total     = h_total_q;
  assign bus.v_total     = v_total_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor with a 16-clock line and 8-line frame,
// active window 8x4 starting at H_START=4 / V_START=2, active-low syncs.
module tb_vga_rx_monitor;
  localparam int HS = 4;
  localparam int HA = 8;
  localparam int VS = 2;
  localparam int VA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_rx_monitor_if bus ();

  vga_rx_monitor #(
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int          done_cnt;
  logic [15:0] done_crc;
  logic [23:0] done_r, done_g, done_b;
  logic [15:0] model_crc;
  logic [15:0] crc_a, crc_b;
  logic [31:0] exp_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-16-CCITT: xor the 12-bit word into the top, then shift.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c ^ {d, 4'b0000};
    for (int i = 0; i < 12; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [11:0] pix_val(input int mode, input int xx);
    logic [3:0] xv;
    xv = 4'(xx);
    case (mode)
      1:       return {xv, ~xv, xv ^ 4'h5};
      2:       return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  // Drives one frame (8 lines of 16 clocks; short_line gets 15). Pins change
  // #1 after each rising edge; outputs seen there reflect pins driven two
  // iterations earlier. hcnt clears on the clock after the hsync edge is
  // seen, so pin position p has hcnt = p-1 and the active columns are
  // p in [HS+1, HS+1+HA).
  task automatic run_frame(input int mode, input int short_line, input bit vs_co,
                           input bit chk_px, input int stop_at);
    logic        hv [2];
    logic [9:0]  hx [2];
    logic [9:0]  hy [2];
    logic [11:0] hp [2];
    logic        act;
    logic [11:0] px;
    int          len, it, vs_start;
    for (int i = 0; i < 2; i++) begin
      hv[i] = 1'b0; hx[i] = '0; hy[i] = '0; hp[i] = '0;
    end
    it = 0;
    done_cnt = 0;
    model_crc = 16'hFFFF;
    vs_start = vs_co ? 0 : 2;
    for (int L = 0; L < 8; L++) begin
      len = (L == short_line) ? 15 : 16;
      for (int p = 0; p < len; p++) begin
        if (it == stop_at) return;
        @(posedge clk); #1;
        if (bus.frame_done === 1'b1) begin
          done_cnt++;
          done_crc = bus.frame_crc;
          done_r = bus.r_sum;
          done_g = bus.g_sum;
          done_b = bus.b_sum;
        end
        if (chk_px) begin
          chk("pixel_valid", 32'(bus.pixel_valid), 32'(hv[1]));
          chk("x", 32'(bus.x), 32'(hx[1]));
          chk("y", 32'(bus.y), 32'(hy[1]));
          if (hv[1]) chk("pixel", 32'(bus.pixel), 32'(hp[1]));
        end
        if (short_line >= 0 && L == short_line + 1 && p == 1)
          chk("locked_before_drop", 32'(bus.locked), 32'd1);
        if (short_line >= 0 && L == short_line + 1 && p == 2)
          chk("locked_drop", 32'(bus.locked), 32'd0);
        act = (L >= VS) && (L < VS + VA) && (p >= HS + 1) && (p < HS + 1 + HA);
        px  = act ? pix_val(mode, p - HS - 1) : 12'hA5C;
        bus.red   = px[11:8];
        bus.green = px[7:4];
        bus.blue  = px[3:0];
        bus.hsync = (p < 2) ? 1'b0 : 1'b1;
        bus.vsync = ((L == 0 && p >= vs_start) || L == 1) ? 1'b0 : 1'b1;
        if (act) model_crc = crc_ref(model_crc, px);
        hv[1] = hv[0]; hx[1] = hx[0]; hy[1] = hy[0]; hp[1] = hp[0];
        hv[0] = act;
        hx[0] = act ? 10'(p - HS - 1) : 10'd0;
        hy[0] = act ? 10'(L - VS) : 10'd0;
        hp[0] = px;
        it++;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
    chk({tag, "_x"},           32'(bus.x),           32'd0);
    chk({tag, "_y"},           32'(bus.y),           32'd0);
    chk({tag, "_pixel"},       32'(bus.pixel),       32'd0);
    chk({tag, "_locked"},      32'(bus.locked),      32'd0);
    chk({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
    chk({tag, "_frame_crc"},   32'(bus.frame_crc),   32'd0);
    chk({tag, "_h_total"},     32'(bus.h_total),     32'd0);
    chk({tag, "_v_total"},     32'(bus.v_total),     32'd0);
    chk({tag, "_r_sum"},       32'(bus.r_sum),       32'd0);
    chk({tag, "_g_sum"},       32'(bus.g_sum),       32'd0);
    chk({tag, "_b_sum"},       32'(bus.b_sum),       32'd0);
  endtask

  initial begin
`ifdef VGA_RX_CHANNEL_SUM_EN
    exp_r = 32'd480;
`else
    exp_r = 32'd0;
`endif
    bus.red = '0; bus.green = '0; bus.blue = '0;
    bus.hsync = 1'b1; bus.vsync = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Acquisition: SEARCH -> MEASURE -> CHECK -> LOCKED over three vs edges.
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f1_locked", 32'(bus.locked), 32'd0);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f2_locked", 32'(bus.locked), 32'd0);
    run_frame(0, -1, 1'b0, 1'b1, -1);
    crc_a = model_crc;
    chk("f3_locked", 32'(bus.locked), 32'd1);
    chk("f3_no_done", 32'(done_cnt), 32'd0);
    chk("f3_h_total", 32'(bus.h_total), 32'd16);
    chk("f3_v_total", 32'(bus.v_total), 32'd8);

    // Ramp frame; first frame_done reports the all-zero frame.
    run_frame(1, -1, 1'b0, 1'b1, -1);
    crc_b = model_crc;
    chk("f4_done_cnt", 32'(done_cnt), 32'd1);
    chk("f4_crc_zero", 32'(done_crc), 32'(crc_a));

    // Short line 3 while locked: ramp CRC reported, then lock drops.
    run_frame(0, 3, 1'b0, 1'b0, -1);
    chk("f5_done_cnt", 32'(done_cnt), 32'd1);
    chk("f5_crc_ramp", 32'(done_crc), 32'(crc_b));
    chk("f5_locked", 32'(bus.locked), 32'd0);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f6_no_done", 32'(done_cnt), 32'd0);
    chk("f6_locked", 32'(bus.locked), 32'd0);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f7_locked", 32'(bus.locked), 32'd0);
    run_frame(2, -1, 1'b0, 1'b0, -1);
    crc_a = model_crc;
    chk("f8_relocked", 32'(bus.locked), 32'd1);
    chk("f8_no_done", 32'(done_cnt), 32'd0);

    // Red-only frame reported: CRC and channel sums.
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f9_done_cnt", 32'(done_cnt), 32'd1);
    chk("f9_crc_red", 32'(done_crc), 32'(crc_a));
    chk("f9_r_sum", 32'(done_r), exp_r);
    chk("f9_g_sum", 32'(done_g), 32'd0);
    chk("f9_b_sum", 32'(done_b), 32'd0);
    chk("f9_r_sum_held", 32'(bus.r_sum), exp_r);

    // vsync edge coincident with hsync edge: line count 7, lock lost.
    run_frame(0, -1, 1'b1, 1'b0, -1);
    chk("f10_v_total", 32'(bus.v_total), 32'd7);
    chk("f10_locked", 32'(bus.locked), 32'd0);
    chk("f10_no_done", 32'(done_cnt), 32'd0);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f11_v_total", 32'(bus.v_total), 32'd8);
    chk("f11_h_total", 32'(bus.h_total), 32'd16);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f13_locked", 32'(bus.locked), 32'd1);

    // No hsync: hcnt saturates at 2047 and lock drops.
    bus.hsync = 1'b1; bus.vsync = 1'b1;
    repeat (1900) @(posedge clk);
    #1;
    chk("idle_still_locked", 32'(bus.locked), 32'd1);
    repeat (200) @(posedge clk);
    #1;
    chk("idle_timeout", 32'(bus.locked), 32'd0);

    run_frame(0, -1, 1'b0, 1'b0, -1);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f16_locked", 32'(bus.locked), 32'd1);

    // Asynchronous reset in the middle of active line 3 (x=1, y=1 at output).
    run_frame(1, -1, 1'b0, 1'b0, 57);
    chk("pre_rst_valid", 32'(bus.pixel_valid), 32'd1);
    chk("pre_rst_x", 32'(bus.x), 32'd1);
    chk("pre_rst_y", 32'(bus.y), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f18_locked", 32'(bus.locked), 32'd0);
    chk("f18_no_done", 32'(done_cnt), 32'd0);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f19_locked", 32'(bus.locked), 32'd0);
    run_frame(1, -1, 1'b0, 1'b1, -1);
    crc_a = model_crc;
    chk("f20_locked", 32'(bus.locked), 32'd1);
    run_frame(0, -1, 1'b0, 1'b0, -1);
    chk("f21_done_cnt", 32'(done_cnt), 32'd1);
    chk("f21_crc_ramp", 32'(done_crc), 32'(crc_a));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
